// File: rtl/sprite_anim_engine.sv
// Per-character sprite engine: frame sequencer driven by a vsync-rate strobe,
// scaled/mirrored sprite ROM addressing and a 2-cycle transparency-keyed pixel path.
module sprite_anim_engine #(
  parameter int unsigned       ADDR_W          = 19,
  parameter int unsigned       COORD_W         = 10,
  parameter int unsigned       DATA_W          = 8,
  parameter int unsigned       ANIM_W          = 3,
  parameter int unsigned       FRAME_W         = 4,
  parameter int unsigned       SCALE_SHIFT     = 1,
  parameter int unsigned       TICKS_PER_FRAME = 4,
  parameter logic [DATA_W-1:0] TRANSPARENT     = '0,
  parameter int unsigned       DEFAULT_ANIM    = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_clk,
  input  logic               anim_req,
  input  logic [ANIM_W-1:0]  anim_id,
  input  logic               anim_once,
  output logic               anim_ack,
  output logic               anim_done,
  input  logic               flip,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  output logic [ANIM_W-1:0]  desc_id,
  input  logic [7:0]         desc_w,
  input  logic [7:0]         desc_h,
  input  logic [FRAME_W-1:0] desc_frames,
  input  logic [ADDR_W-1:0]  desc_base,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_data,
  output logic [FRAME_W-1:0] cur_frame,
  output logic               pix_on,
  output logic [DATA_W-1:0]  pix_data
);

  localparam int unsigned TICK_W = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
  localparam int unsigned SPAN_W = 8 + SCALE_SHIFT;
  localparam int unsigned CMP_W  = (COORD_W > SPAN_W) ? COORD_W : SPAN_W;

  typedef enum logic [1:0] {
    ST_LOOP,
    ST_ONCE,
    ST_HOLD_DONE
  } state_t;

  // Synchroniser is preset high so a level already high at reset is not an edge.
  logic fc_s1, fc_s2, fc_prev;
  logic frame_tick;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_s1   <= 1'b1;
      fc_s2   <= 1'b1;
      fc_prev <= 1'b1;
    end else begin
      fc_s1   <= frame_clk;
      fc_s2   <= fc_s1;
      fc_prev <= fc_s2;
    end
  end

  assign frame_tick = fc_s2 & ~fc_prev;

  state_t              state;
  logic [TICK_W-1:0]   tick_cnt;
  logic [COORD_W-1:0]  pos_x_lat;
  logic [COORD_W-1:0]  pos_y_lat;
  logic [FRAME_W-1:0]  last_frame;
  logic                tick_wrap;

  // Zero-frame descriptors behave as single-frame animations.
  assign last_frame = (desc_frames == '0) ? '0 : desc_frames - FRAME_W'(1);
  assign tick_wrap  = (tick_cnt == TICK_W'(TICKS_PER_FRAME - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_LOOP;
      desc_id   <= ANIM_W'(DEFAULT_ANIM);
      cur_frame <= '0;
      tick_cnt  <= '0;
      pos_x_lat <= '0;
      pos_y_lat <= '0;
      anim_ack  <= 1'b0;
      anim_done <= 1'b0;
    end else begin
      anim_ack  <= anim_req;
      anim_done <= 1'b0;
      if (frame_tick) begin
        pos_x_lat <= pos_x;
        pos_y_lat <= pos_y;
      end
      // A request swallows a coincident tick so the new animation starts clean.
      if (anim_req) begin
        desc_id   <= anim_id;
        state     <= anim_once ? ST_ONCE : ST_LOOP;
        cur_frame <= '0;
        tick_cnt  <= '0;
      end else begin
        case (state)
          ST_HOLD_DONE: begin
            desc_id   <= ANIM_W'(DEFAULT_ANIM);
            state     <= ST_LOOP;
            cur_frame <= '0;
            tick_cnt  <= '0;
          end
          default: begin
            if (frame_tick) begin
              if (!tick_wrap) begin
                tick_cnt <= tick_cnt + TICK_W'(1);
              end else begin
                tick_cnt <= '0;
                if (cur_frame < last_frame) begin
                  cur_frame <= cur_frame + FRAME_W'(1);
                end else if (state == ST_ONCE) begin
                  state     <= ST_HOLD_DONE;
                  anim_done <= 1'b1;
                end else begin
                  cur_frame <= '0;
                end
              end
            end
          end
        endcase
      end
    end
  end

  // Address stage: explicit >= guards keep DrawX < pos from wrapping into a hit.
  logic [COORD_W-1:0] dx, dy, sx, sy;
  logic [CMP_W-1:0]   span_w, span_h;
  logic               hit;
  logic [ADDR_W-1:0]  col, frame_size, frame_off, row_off, addr_c;

  assign dx     = DrawX - pos_x_lat;
  assign dy     = DrawY - pos_y_lat;
  assign span_w = CMP_W'(desc_w) << SCALE_SHIFT;
  assign span_h = CMP_W'(desc_h) << SCALE_SHIFT;
  assign hit    = (DrawX >= pos_x_lat) && (DrawY >= pos_y_lat) &&
                  (CMP_W'(dx) < span_w) && (CMP_W'(dy) < span_h);
  assign sx     = dx >> SCALE_SHIFT;
  assign sy     = dy >> SCALE_SHIFT;

  assign col        = flip ? (ADDR_W'(desc_w) - ADDR_W'(1) - ADDR_W'(sx)) : ADDR_W'(sx);
  assign frame_size = ADDR_W'(desc_w) * ADDR_W'(desc_h);
  assign frame_off  = ADDR_W'(cur_frame) * frame_size;
  assign row_off    = ADDR_W'(sy) * ADDR_W'(desc_w);
  assign addr_c     = desc_base + frame_off + row_off + col;

  logic hit_d, hit_dd;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom_addr <= '0;
      hit_d    <= 1'b0;
      hit_dd   <= 1'b0;
    end else begin
      rom_addr <= hit ? addr_c : desc_base;
      hit_d    <= hit;
      hit_dd   <= hit_d;
    end
  end

  // Keyed straight off the registered ROM output to hold the 2-cycle latency.
  assign pix_on   = hit_dd && (rom_data != TRANSPARENT);
  assign pix_data = pix_on ? rom_data : '0;

endmodule

// File: tb/tb_sprite_anim_engine.sv
// Bench for sprite_anim_engine: directed test-plan steps followed by random
// stimulus, all checked every cycle against a tick-counting reference model.
module tb_sprite_anim_engine;

  localparam int unsigned ADDR_W   = 19;
  localparam int unsigned COORD_W  = 10;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned ANIM_W   = 3;
  localparam int unsigned FRAME_W  = 4;
  localparam int unsigned SHIFT    = 1;
  localparam int unsigned TPF      = 4;
  localparam int unsigned DEF_ANIM = 0;

  logic               Clk = 1'b0;
  logic               Reset, frame_clk, anim_req, anim_once, flip;
  logic [ANIM_W-1:0]  anim_id, desc_id;
  logic               anim_ack, anim_done, pix_on;
  logic [COORD_W-1:0] pos_x, pos_y, DrawX, DrawY;
  logic [7:0]         desc_w, desc_h;
  logic [FRAME_W-1:0] desc_frames, cur_frame;
  logic [ADDR_W-1:0]  desc_base, rom_addr;
  logic [DATA_W-1:0]  rom_data, pix_data;

  always #10 Clk = ~Clk;

  sprite_anim_engine dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .anim_req(anim_req), .anim_id(anim_id), .anim_once(anim_once),
    .anim_ack(anim_ack), .anim_done(anim_done), .flip(flip),
    .pos_x(pos_x), .pos_y(pos_y), .DrawX(DrawX), .DrawY(DrawY),
    .desc_id(desc_id), .desc_w(desc_w), .desc_h(desc_h),
    .desc_frames(desc_frames), .desc_base(desc_base),
    .rom_addr(rom_addr), .rom_data(rom_data), .cur_frame(cur_frame),
    .pix_on(pix_on), .pix_data(pix_data)
  );

  // Descriptor table and sprite ROM contents
  logic [7:0]         t_w [8];
  logic [7:0]         t_h [8];
  logic [FRAME_W-1:0] t_f [8];
  logic [ADDR_W-1:0]  t_b [8];
  bit                 zero_mode = 1'b0;

  assign desc_w      = t_w[desc_id];
  assign desc_h      = t_h[desc_id];
  assign desc_frames = t_f[desc_id];
  assign desc_base   = t_b[desc_id];

  function automatic logic [7:0] rom_fn(input logic [ADDR_W-1:0] a);
    if (zero_mode) return 8'h00;
    return 8'(a * 7 + 19'h5A) ^ 8'(a >> 8);
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr);

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: animation tracked as ticks elapsed since it started
  int     m_id, m_total, m_px, m_py;
  bit     m_once, m_hold;
  bit     fh0, fh1, fh2;
  bit     e_ack, e_done, e_hit, e_pix_on;
  logic [7:0] e_pix;
  longint e_addr;

  function automatic int frames_of(input int id);
    int f;
    f = int'(t_f[id]);
    return (f == 0) ? 1 : f;
  endfunction

  function automatic int model_frame();
    int nf;
    nf = frames_of(m_id);
    if (m_hold) return nf - 1;
    if (m_once) return m_total / TPF;
    return (m_total / TPF) % nf;
  endfunction

  task automatic model(input bit r, input bit rq, input int id, input bit on, input bit fl,
                       input bit fc, input int x, input int y, input int pxi, input int pyi);
    longint w, h, b, dxl, dyl, sx, sy, col, a;
    bit hit, tick;
    logic [7:0] rv;
    if (r) begin
      m_id = DEF_ANIM; m_once = 0; m_total = 0; m_hold = 0; m_px = 0; m_py = 0;
      fh0 = 1; fh1 = 1; fh2 = 1;
      e_ack = 0; e_done = 0; e_hit = 0; e_pix_on = 0; e_pix = 8'h00; e_addr = 0;
      return;
    end
    rv = rom_fn(ADDR_W'(e_addr));
    e_pix_on = e_hit && (rv != 8'h00);
    e_pix = e_pix_on ? rv : 8'h00;
    w = longint'(t_w[m_id]); h = longint'(t_h[m_id]); b = longint'(t_b[m_id]);
    dxl = x - m_px; dyl = y - m_py;
    hit = (x >= m_px) && (y >= m_py) && (dxl < (w << SHIFT)) && (dyl < (h << SHIFT));
    sx = dxl >>> SHIFT; sy = dyl >>> SHIFT;
    col = fl ? (w - 1 - sx) : sx;
    a = b + longint'(model_frame()) * w * h + sy * w + col;
    e_hit = hit;
    e_addr = hit ? (a % (longint'(1) << ADDR_W)) : b;
    tick = fh1 && !fh2;
    fh2 = fh1; fh1 = fh0; fh0 = fc;
    e_ack = rq; e_done = 0;
    if (tick) begin m_px = pxi; m_py = pyi; end
    if (rq) begin
      m_id = id; m_once = on; m_total = 0; m_hold = 0;
    end else if (m_hold) begin
      m_id = DEF_ANIM; m_once = 0; m_total = 0; m_hold = 0;
    end else if (tick) begin
      m_total++;
      if (m_once && m_total == TPF * frames_of(m_id)) begin
        e_done = 1; m_hold = 1;
      end
    end
  endtask

  int done_cnt, max_frame, post_id, post_frame;
  bit prev_done;

  task automatic step();
    bit r, rq, on, fl, fc;
    int id, x, y, pxi, pyi;
    r = Reset; rq = anim_req; on = anim_once; fl = flip; fc = frame_clk;
    id = int'(anim_id); x = int'(DrawX); y = int'(DrawY);
    pxi = int'(pos_x); pyi = int'(pos_y);
    @(posedge Clk); #1;
    model(r, rq, id, on, fl, fc, x, y, pxi, pyi);
    chk("anim_ack", 32'(anim_ack), 32'(e_ack));
    chk("anim_done", 32'(anim_done), 32'(e_done));
    chk("desc_id", 32'(desc_id), 32'(m_id));
    chk("cur_frame", 32'(cur_frame), 32'(model_frame()));
    chk("rom_addr", 32'(rom_addr), 32'(e_addr));
    chk("pix_on", 32'(pix_on), 32'(e_pix_on));
    chk("pix_data", 32'(pix_data), 32'(e_pix));
    if (prev_done) begin post_id = int'(desc_id); post_frame = int'(cur_frame); end
    prev_done = (anim_done === 1'b1);
    if (anim_done === 1'b1) done_cnt++;
    if (int'(cur_frame) > max_frame) max_frame = int'(cur_frame);
  endtask

  task automatic fc_pulse();
    frame_clk = 1'b1;
    repeat (3) step();
    frame_clk = 1'b0;
    repeat (3) step();
  endtask

  task automatic present(input int x, input int y, output logic [ADDR_W-1:0] a1, output logic p2);
    DrawX = COORD_W'(x); DrawY = COORD_W'(y);
    step(); a1 = rom_addr;
    step(); p2 = pix_on;
  endtask

  logic [ADDR_W-1:0] a1;
  logic              p2;

  initial begin
    t_w[0] = 8'd37;  t_h[0] = 8'd51;  t_f[0] = 4'd6;  t_b[0] = 19'd0;
    t_w[1] = 8'd16;  t_h[1] = 8'd20;  t_f[1] = 4'd3;  t_b[1] = 19'd40000;
    t_w[2] = 8'd8;   t_h[2] = 8'd8;   t_f[2] = 4'd0;  t_b[2] = 19'd1000;
    t_w[3] = 8'd24;  t_h[3] = 8'd32;  t_f[3] = 4'd4;  t_b[3] = 19'd100000;
    t_w[4] = 8'd64;  t_h[4] = 8'd48;  t_f[4] = 4'd5;  t_b[4] = 19'd200000;
    t_w[5] = 8'd10;  t_h[5] = 8'd12;  t_f[5] = 4'd1;  t_b[5] = 19'd300000;
    t_w[6] = 8'd255; t_h[6] = 8'd255; t_f[6] = 4'd15; t_b[6] = 19'd400000;
    t_w[7] = 8'd3;   t_h[7] = 8'd5;   t_f[7] = 4'd7;  t_b[7] = 19'd500000;
    Reset = 1'b1; frame_clk = 1'b0; anim_req = 1'b0; anim_id = '0; anim_once = 1'b0;
    flip = 1'b0; pos_x = '0; pos_y = '0; DrawX = '0; DrawY = '0;
    done_cnt = 0; max_frame = 0; post_id = 7; post_frame = 15; prev_done = 0;

    // Reset state
    repeat (3) step();
    chk("rst_desc_id", 32'(desc_id), 32'd0);
    chk("rst_cur_frame", 32'(cur_frame), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_pix_on", 32'(pix_on), 32'd0);
    Reset = 1'b0;
    step();

    // Plain addressing at (100,300), scale 2
    pos_x = 10'd100; pos_y = 10'd300;
    fc_pulse();
    present(100, 300, a1, p2);
    chk("t1_addr_origin", 32'(a1), 32'd0);
    chk("t1_pix_origin", 32'(p2), 32'(rom_fn(19'd0) != 8'h00));
    present(173, 300, a1, p2);
    chk("t1_addr_right", 32'(a1), 32'd36);
    present(174, 300, a1, p2);
    chk("t1_pix_outside", 32'(p2), 32'd0);

    // Mirrored addressing
    flip = 1'b1;
    present(100, 300, a1, p2);
    chk("t2_flip_left", 32'(a1), 32'd36);
    present(173, 300, a1, p2);
    chk("t2_flip_right", 32'(a1), 32'd0);
    repeat (7) fc_pulse();
    chk("t2_frame2", 32'(cur_frame), 32'd2);
    present(100, 302, a1, p2);
    chk("t2_flip_frame2", 32'(a1), 32'd3847);
    flip = 1'b0;

    // Looping: 6 frames of 4 ticks each
    anim_req = 1'b1; anim_id = 3'd0; anim_once = 1'b0;
    step();
    anim_req = 1'b0;
    max_frame = 0; done_cnt = 0;
    repeat (20) fc_pulse();
    chk("t3_frame_last", 32'(cur_frame), 32'd5);
    repeat (4) fc_pulse();
    chk("t3_wrap", 32'(cur_frame), 32'd0);
    chk("t3_max_frame", 32'(max_frame), 32'd5);
    chk("t3_no_done", 32'(done_cnt), 32'd0);

    // One-shot then fall back to the default loop
    anim_req = 1'b1; anim_id = 3'd1; anim_once = 1'b1;
    step();
    chk("t4_ack", 32'(anim_ack), 32'd1);
    anim_req = 1'b0;
    step();
    chk("t4_ack_pulse", 32'(anim_ack), 32'd0);
    repeat (11) fc_pulse();
    chk("t4_not_done_yet", 32'(done_cnt), 32'd0);
    fc_pulse();
    chk("t4_done_once", 32'(done_cnt), 32'd1);
    chk("t4_post_id", 32'(post_id), 32'(DEF_ANIM));
    chk("t4_post_frame", 32'(post_frame), 32'd0);

    // Transparency, wrap guard and request coinciding with a tick
    zero_mode = 1'b1;
    present(110, 310, a1, p2);
    chk("t5_transparent", 32'(p2), 32'd0);
    zero_mode = 1'b0;
    pos_x = 10'd600;
    fc_pulse();
    present(5, 300, a1, p2);
    chk("t5_no_wrap_pix", 32'(p2), 32'd0);
    chk("t5_no_wrap_addr", 32'(a1), 32'(t_b[0]));
    pos_x = 10'd100;
    repeat (5) fc_pulse();
    frame_clk = 1'b1;
    step(); step();
    anim_req = 1'b1; anim_id = 3'd3; anim_once = 1'b0;
    step();
    anim_req = 1'b0; frame_clk = 1'b0;
    repeat (3) step();
    chk("t5_req_tick_frame", 32'(cur_frame), 32'd0);
    repeat (3) fc_pulse();
    chk("t5_tick_cnt_clear", 32'(cur_frame), 32'd0);
    fc_pulse();
    chk("t5_first_advance", 32'(cur_frame), 32'd1);

    // Reset mid one-shot, then position latching only on ticks
    anim_req = 1'b1; anim_id = 3'd1; anim_once = 1'b1;
    step();
    anim_req = 1'b0;
    repeat (8) fc_pulse();
    chk("t6_frame2", 32'(cur_frame), 32'd2);
    frame_clk = 1'b1; Reset = 1'b1;
    step();
    chk("t6_rst_desc_id", 32'(desc_id), 32'd0);
    chk("t6_rst_frame", 32'(cur_frame), 32'd0);
    chk("t6_rst_ack", 32'(anim_ack), 32'd0);
    chk("t6_rst_done", 32'(anim_done), 32'd0);
    chk("t6_rst_addr", 32'(rom_addr), 32'd0);
    chk("t6_rst_pix_on", 32'(pix_on), 32'd0);
    chk("t6_rst_pix_data", 32'(pix_data), 32'd0);
    Reset = 1'b0;
    repeat (4) step();
    frame_clk = 1'b0;
    repeat (3) step();
    pos_x = 10'd100; pos_y = 10'd300;
    fc_pulse();
    pos_x = 10'd200;
    step(); step();
    present(110, 300, a1, p2);
    chk("t6_pos_held", 32'(a1), 32'd5);
    fc_pulse();
    present(110, 300, a1, p2);
    chk("t6_pos_moved", 32'(a1), 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) frame_clk = ~frame_clk;
      anim_req  = ($urandom_range(0, 99) == 0);
      anim_id   = ANIM_W'($urandom_range(0, 7));
      anim_once = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) flip = ~flip;
      if ($urandom_range(0, 199) == 0) begin
        pos_x = COORD_W'($urandom_range(0, 1023));
        pos_y = COORD_W'($urandom_range(0, 1023));
      end
      Reset = ($urandom_range(0, 999) == 0);
      DrawX = COORD_W'(int'(pos_x) + int'($urandom_range(0, 160)) - 20);
      DrawY = COORD_W'(int'(pos_y) + int'($urandom_range(0, 160)) - 20);
      step();
    end
    Reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
